spell_sram_port: RTL
====================

# spell_sram_port

Byte-to-word bridge between the SPELL memory unit and the shared OpenRAM wishbone bus. Accepts single-byte code/data accesses using the select/data_ready handshake and turns each one into a 32-bit rambus wishbone cycle with the correct byte lane. Holds a one-word write-through read buffer, so repeated fetches from the same word complete without a bus cycle. A bus watchdog stops a missing ack from hanging the core.

## Interface
- TIMEOUT_CYCLES, 255: cycles a bus cycle may stay open without ack before it is aborted; range 2..255.
- clock  input  1  system clock; the rambus is also clocked by it
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- select  input  1  request valid; held high until data_ready is seen
- addr  input  8  byte address
- memory_type_data  input  1  1 = data space, 0 = code space
- write  input  1  1 = write data_in, 0 = read
- data_in  input  8  write byte
- flush  input  1  single-cycle pulse that invalidates the read buffer
- error_clear  input  1  clears bus_error
- data_out  output  8  read byte; valid while data_ready is high
- data_ready  output  1  single-cycle completion pulse
- bus_error  output  1  sticky flag set on watchdog abort
- sram_cyc_o, sram_stb_o, sram_we_o  output  1 each  wishbone cycle, strobe, write enable
- sram_sel_o  output  4  byte lane select
- sram_dat_o  output  32  write data
- sram_addr_o  output  10  word address
- sram_ack_i  input  1  wishbone ack
- sram_dat_i  input  32  wishbone read data

## Operation
- Word address is {3'b0, memory_type_data, addr[7:2]}. Byte lane is addr[1:0]; lane 0 is bits [7:0].
- Read buffer: a 32-bit word, a 7-bit tag {memory_type_data, addr[7:2]} and a valid bit.
- States:
  - IDLE: when select=1, a read whose tag matches a valid buffer is a hit and goes to DONE. Every other request (read miss or any write) goes to BUS.
  - BUS: cyc=stb=1. sram_we_o = write. sram_sel_o = 4'hF on a read; on a write it is 1<<addr[1:0]. sram_dat_o = {4{data_in}}.
  - DONE: data_ready is high for exactly this cycle. Next state is WAIT.
  - WAIT: stays here until select=0, then returns to IDLE. This stops a held select from starting a second access.
- Ack in BUS:
  - Read: loads the buffer with sram_dat_i and the tag, sets valid, and sets data_out to the lane byte.
  - Write: write-through. If the write's tag hits the buffer, the buffer lane is updated with data_in. On a write, data_out = data_in.
  - Either case then goes to DONE.
- Watchdog:
  - An 8-bit counter clears on entry to BUS and increments every BUS cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the block drops cyc/stb, sets data_out=8'hFF, sets bus_error=1, leaves the buffer unchanged and goes to DONE.
- If select falls during BUS, the bus cycle still completes and the buffer still updates. DONE is entered, but data_ready is suppressed; the block goes straight to WAIT and then IDLE.
- flush clears valid in any state. If flush coincides with a fill, flush wins and valid ends at 0.
- error_clear clears bus_error. If it coincides with a new timeout, the set wins.

## Timing
- Reset (async assert) forces:
  - state IDLE
  - all sram_* outputs 0
  - data_out=0, data_ready=0, bus_error=0
  - buffer valid=0, counter=0
- If reset occurs in the middle of a bus cycle, cyc/stb drop immediately; no completion is reported.
- Release is synchronous to the clock: the first request is accepted on the first edge with reset=1.
- Read hit: select is sampled high at edge N; data_ready is high in cycle N+1. Latency 1, no bus activity.
- Miss or write:
  - select is sampled at edge N; cyc/stb are high from N+1.
  - ack is sampled at edge M; cyc/stb are low and data_ready is high from M+1.
  - Best case, ack in the first BUS cycle, gives latency 2.
- An ack and the timeout in the same cycle: ack wins, and bus_error is not set.
- All outputs are registered. sram_addr_o, sram_sel_o, sram_dat_o and sram_we_o are stable for the whole cycle.
- Minimum spacing between requests: one cycle with select=0.

## Test plan
- **Reset:** hold reset=0, toggle inputs. Then drive reset=0 while BUS is active. → All outputs 0; cyc drops without waiting for an edge.
- **Read miss then hit:**
  - Step 1: read code addr 8'h05 with sram_dat_i=32'hDDCCBBAA and ack one cycle after stb. → sram_addr_o=10'h001, sel=4'hF, data_out=8'hBB, data_ready one cycle.
  - Step 2: read addr 8'h07. → No cyc; data_out=8'hDD one cycle after select.
- **Write-through:**
  - Step 1: write data addr 8'h42 with data_in=8'h5A. → sram_addr_o=10'h050, sel=4'b0100, dat_o=32'h5A5A5A5A, we=1.
  - Step 2: read 8'h42 after the buffer was filled from that word. → Hit returns 8'h5A.
- **Space separation:** fill the buffer from code word 0, then read data addr 8'h00. → Miss, with a bus cycle at sram_addr_o=10'h040.
- **Timeout:** set TIMEOUT_CYCLES=4 and never ack. → cyc drops after 3 BUS cycles, data_out=8'hFF, bus_error=1. Then error_clear → bus_error=0.
- **Flush and held select:**
  - flush in the same cycle as a fill ack → the next read of that word misses.
  - Holding select high after data_ready → no second bus cycle until select has been low for one cycle.

Source files
------------

// File: rtl/spell_sram_port.sv
// rtl/spell_sram_port.sv - SPELL byte access to 32-bit rambus wishbone bridge with one-word read buffer
module spell_sram_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        select,
    input  logic [7:0]  addr,
    input  logic        memory_type_data,
    input  logic        write,
    input  logic [7:0]  data_in,
    input  logic        flush,
    input  logic        error_clear,
    output logic [7:0]  data_out,
    output logic        data_ready,
    output logic        bus_error,
    output logic        sram_cyc_o,
    output logic        sram_stb_o,
    output logic        sram_we_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_dat_o,
    output logic [9:0]  sram_addr_o,
    input  logic        sram_ack_i,
    input  logic [31:0] sram_dat_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_WAIT} state_t;

    // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 2);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_buf;
    logic [6:0]  r_tag;
    logic        r_valid;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lane;
    logic        r_dropped;

    logic [6:0]  w_tag;
    logic        w_hit;
    logic        w_abort;
    logic        w_report;
    logic [7:0]  w_buf_byte;
    logic [7:0]  w_bus_byte;

    assign w_tag      = {memory_type_data, addr[7:2]};
    assign w_hit      = !write && r_valid && (r_tag == w_tag);
    assign w_abort    = (r_state == S_BUS) && !sram_ack_i && (r_cnt == LP_LAST);
    assign w_report   = select && !r_dropped;
    assign w_buf_byte = r_buf[{addr[1:0], 3'b000} +: 8];
    assign w_bus_byte = sram_dat_i[{r_lane, 3'b000} +: 8];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (select) begin
                    w_next = w_hit ? S_DONE : S_BUS;
                end
            end
            S_BUS: begin
                if (sram_ack_i || w_abort) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_WAIT;
            S_WAIT: begin
                if (!select) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out    <= 8'h00;
            data_ready  <= 1'b0;
            bus_error   <= 1'b0;
            sram_cyc_o  <= 1'b0;
            sram_stb_o  <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_sel_o  <= 4'h0;
            sram_dat_o  <= 32'h0;
            sram_addr_o <= 10'h000;
            r_buf       <= 32'h0;
            r_tag       <= 7'h00;
            r_valid     <= 1'b0;
            r_cnt       <= 8'h00;
            r_lane      <= 2'b00;
            r_dropped   <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (error_clear) begin
                bus_error <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (select && w_hit) begin
                        data_out   <= w_buf_byte;
                        data_ready <= 1'b1;
                    end else if (select) begin
                        sram_cyc_o  <= 1'b1;
                        sram_stb_o  <= 1'b1;
                        sram_we_o   <= write;
                        sram_sel_o  <= write ? (4'b0001 << addr[1:0]) : 4'hF;
                        sram_dat_o  <= {4{data_in}};
                        sram_addr_o <= {3'b000, w_tag};
                        r_lane      <= addr[1:0];
                        r_cnt       <= 8'h00;
                        r_dropped   <= 1'b0;
                    end
                end
                S_BUS: begin
                    if (!select) begin
                        r_dropped <= 1'b1;
                    end
                    if (sram_ack_i || w_abort) begin
                        sram_cyc_o  <= 1'b0;
                        sram_stb_o  <= 1'b0;
                        sram_we_o   <= 1'b0;
                        sram_sel_o  <= 4'h0;
                        sram_dat_o  <= 32'h0;
                        sram_addr_o <= 10'h000;
                        data_ready  <= w_report;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (sram_ack_i && sram_we_o) begin
                        data_out <= sram_dat_o[7:0];
                        // Write-through keeps the buffered copy coherent with memory.
                        if (r_valid && (r_tag == sram_addr_o[6:0])) begin
                            r_buf[{r_lane, 3'b000} +: 8] <= sram_dat_o[7:0];
                        end
                    end else if (sram_ack_i) begin
                        data_out <= w_bus_byte;
                        r_buf    <= sram_dat_i;
                        r_tag    <= sram_addr_o[6:0];
                        r_valid  <= 1'b1;
                    end else if (w_abort) begin
                        data_out  <= 8'hFF;
                        bus_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (flush) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
